// File: rtl/cpu_pkg.sv
// Shared CPU types: fetch geometry defaults, opcode encoding, fetch FSM states.
// No logic; imported by the fetch block and its buffer.
package cpu_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_OPC_W  = 3;

    typedef enum logic [2:0] {
        HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP
    } opcode_e;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t IDLE = 2'd0;
    localparam fetch_state_t REQ  = 2'd1;
    localparam fetch_state_t HOLD = 2'd2;

endpackage

// File: rtl/instr_buf.sv
// One-entry valid/data holding register with synchronous clear.
// Latency: load visible the cycle after the loading edge.
// Backpressure: none internally; load takes priority over unload, clear over both.
module instr_buf
    import cpu_pkg::*;
#(
    parameter int W = DEF_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] load_dat,
    output logic         buf_vld,
    output logic [W-1:0] buf_dat
);

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld <= 1'b0;
            buf_dat <= '0;
        end else if (clr) begin
            buf_vld <= 1'b0;
        end else if (load) begin
            buf_vld <= 1'b1;
            buf_dat <= load_dat;
        end else if (unload) begin
            buf_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: reads program memory at the PC and hands opcode/operand to the controller (FETCH_PREFETCH_EN adds a one-word prefetch slot).
// Latency: mem_ack to ir_valid 1 clk; IR accept to next mem_rd 1 clk (back-to-back words with prefetch and 1-clk memory).
// Backpressure: ir_ready low holds IR and stalls fetching (one extra word buffered with prefetch); flush drops everything.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int OPC_W  = DEF_OPC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       pc_addr,
    output logic                    pc_inc,
    input  logic                    flush,
    output logic                    mem_rd,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_ack,
    output logic                    ir_valid,
    input  logic                    ir_ready,
    output logic [OPC_W-1:0]        ir_opcode,
    output logic [DATA_W-OPC_W-1:0] ir_operand
);

`ifdef FETCH_PREFETCH_EN
    localparam logic [1:0] CAP = 2'd2;
`else
    localparam logic [1:0] CAP = 2'd1;
`endif

    fetch_state_t      state;
    logic              ir_vld, pf_vld;
    logic [DATA_W-1:0] ir_dat, pf_dat, ir_load_dat;
    logic              fill, accept, fill_to_ir, ir_load, keep_rd, issue;
    logic [1:0]        occ_nxt;

    assign fill        = (state == REQ) && mem_ack && !flush;
    assign accept      = ir_vld && ir_ready && !flush;
    assign pc_inc      = fill;
    assign mem_rd      = (state == REQ);
    assign fill_to_ir  = fill && (!ir_vld || (accept && !pf_vld));
    assign ir_load     = fill_to_ir || (accept && pf_vld);
    assign ir_load_dat = (accept && pf_vld) ? pf_dat : mem_rdata;
    assign occ_nxt     = {1'b0, ir_vld} + {1'b0, pf_vld} + {1'b0, fill} - {1'b0, accept};
    assign keep_rd     = (state == REQ) && !mem_ack;
    // Only request when the returning word is guaranteed a free slot.
    assign issue       = (state == IDLE) || (!keep_rd && (occ_nxt < CAP));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mem_addr <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else if (keep_rd) begin
            state <= REQ;
        end else if (issue) begin
            state    <= REQ;
            // On an ack edge the counter advances at the same edge, so aim one past it.
            mem_addr <= pc_addr + ADDR_W'(fill);
        end else begin
            state <= HOLD;
        end
    end

    instr_buf #(.W(DATA_W)) u_ir (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .load     (ir_load),
        .unload   (accept),
        .load_dat (ir_load_dat),
        .buf_vld  (ir_vld),
        .buf_dat  (ir_dat)
    );

`ifdef FETCH_PREFETCH_EN
    instr_buf #(.W(DATA_W)) u_pf (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .load     (fill && !fill_to_ir),
        .unload   (accept),
        .load_dat (mem_rdata),
        .buf_vld  (pf_vld),
        .buf_dat  (pf_dat)
    );
`else
    assign pf_vld = 1'b0;
    assign pf_dat = '0;
`endif

    assign ir_valid   = ir_vld;
    assign ir_opcode  = ir_dat[DATA_W-1 -: OPC_W];
    assign ir_operand = ir_dat[DATA_W-OPC_W-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: models the program counter and a variable-latency memory, scoreboards delivered words.
// Build with FETCH_PREFETCH_EN defined to exercise the prefetch variant.
module tb_instr_fetch;

`ifdef FETCH_PREFETCH_EN
    localparam int CAP = 2;
    localparam bit PF  = 1'b1;
`else
    localparam int CAP = 1;
    localparam bit PF  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, pc_inc, flush, mem_rd, mem_ack, ir_valid, ir_ready;
    logic [4:0] pc, mem_addr, ir_operand;
    logic [7:0] mem_rdata;
    logic [2:0] ir_opcode;

    instr_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .pc_addr    (pc),
        .pc_inc     (pc_inc),
        .flush      (flush),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .ir_opcode  (ir_opcode),
        .ir_operand (ir_operand)
    );

    always #5 clk = ~clk;

    int         n_chk = 0, n_err = 0;
    logic [7:0] mem [32];
    logic [7:0] q[$];
    logic [4:0] ack_log[$];
    logic [7:0] acc_log[$];
    logic [4:0] fetch_ptr, flush_tgt, prev_addr;
    logic [7:0] prev_word, w0;
    int         wcnt, cur_dly, fix_dly, ready_pct, rand_flush_pct;
    int         n_inc, n_acc, n_ack, a0;
    bit         stray_en, flush_now, flush_on_ack, fa_hit;
    logic       last_flush_inc;
    logic       prev_rd, prev_ack, prev_flush, prev_irv, prev_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs after negedge, check at +1, advance counter model after posedge.
    task automatic cycle();
        logic       ack_now, acc_now, inc_now;
        logic [7:0] word, exp_w;
        if (mem_rd) begin
            if (wcnt == 0) cur_dly = (fix_dly != 0) ? fix_dly : int'($urandom_range(1, 3));
            wcnt++;
            mem_ack   = (wcnt >= cur_dly);
            mem_rdata = mem_ack ? mem[mem_addr] : 8'($urandom);
        end else begin
            mem_ack   = stray_en && ($urandom_range(0, 7) == 0);
            mem_rdata = 8'($urandom);
        end
        ir_ready = ($urandom_range(0, 99) < ready_pct);
        flush = 1'b0;
        if (flush_on_ack && mem_rd && mem_ack) begin
            flush = 1'b1; flush_on_ack = 1'b0; fa_hit = 1'b1;
        end else if (flush_now) begin
            flush = 1'b1; flush_now = 1'b0;
        end else if (rand_flush_pct != 0 && $urandom_range(0, 99) < rand_flush_pct) begin
            flush = 1'b1; flush_tgt = 5'($urandom);
        end
        #1;
        ack_now = mem_rd && mem_ack;
        acc_now = ir_valid && ir_ready && !flush;
        inc_now = pc_inc;
        word    = {ir_opcode, ir_operand};
        if (flush) last_flush_inc = pc_inc;
        if (!rst) begin
            chk("ir_valid", ir_valid, q.size() != 0);
            if (prev_irv && !prev_acc && !prev_flush) chk("ir_stable", word, prev_word);
            if (prev_rd && !prev_ack && !prev_flush) begin
                chk("rd_held", mem_rd, 1);
                chk("addr_held", mem_addr, prev_addr);
            end
            chk("pc_inc", pc_inc, ack_now && !flush);
            n_inc += int'(pc_inc);
            if (acc_now && q.size() != 0) begin
                exp_w = q.pop_front();
                chk("ir_word", word, exp_w);
                acc_log.push_back(word);
                n_acc++;
            end
            if (ack_now && !flush) begin
                chk("fetch_addr", mem_addr, fetch_ptr);
                q.push_back(mem_rdata);
                ack_log.push_back(mem_addr);
                fetch_ptr++;
                n_ack++;
            end
            chk("occupancy", q.size() <= CAP, 1);
            if (flush) begin
                q.delete(); ack_log.delete(); acc_log.delete();
                fetch_ptr = flush_tgt; n_inc = 0; n_acc = 0;
            end
        end
        prev_rd = mem_rd; prev_ack = ack_now; prev_flush = flush;
        prev_irv = ir_valid; prev_acc = acc_now; prev_addr = mem_addr; prev_word = word;
        @(posedge clk);
        #1;
        if (rst) pc = '0;
        else if (flush) pc = flush_tgt;
        else if (inc_now) pc = pc + 5'd1;
        if (ack_now || flush || !mem_rd || rst) wcnt = 0;
        @(negedge clk);
    endtask

    task automatic do_flush(input logic [4:0] tgt);
        flush_now = 1'b1;
        flush_tgt = tgt;
        cycle();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0; ir_ready = 1'b0; pc = '0;
        ready_pct = 100; fix_dly = 0; rand_flush_pct = 0; stray_en = 1'b0;
        flush_now = 1'b0; flush_on_ack = 1'b0; fa_hit = 1'b0; last_flush_inc = 1'b0;
        wcnt = 0; cur_dly = 1; n_inc = 0; n_acc = 0; n_ack = 0; fetch_ptr = '0; flush_tgt = '0;
        prev_rd = 0; prev_ack = 0; prev_flush = 0; prev_irv = 0; prev_acc = 0; prev_addr = '0; prev_word = '0;
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        mem[0]  = 8'hBD;
        mem[31] = 8'hE3;
        @(negedge clk);

        // Reset state
        repeat (2) cycle();
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_pc_inc", pc_inc, 0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_opcode", ir_opcode, 0);
        chk("rst_operand", ir_operand, 0);
        rst = 1'b0; pc = '0; fetch_ptr = '0; n_inc = 0; n_acc = 0; q.delete();
        cycle();
        chk("first_rd", mem_rd, 1);
        chk("first_addr", mem_addr, 5'h00);

        // First word, 2-clk memory
        fix_dly = 2;
        for (int k = 0; k < 20 && !ir_valid; k++) cycle();
        chk("first_valid_timeout", ir_valid, 1);
        chk("first_opcode", ir_opcode, 3'b101);
        chk("first_operand", ir_operand, 5'h1D);
        chk("first_inc_cnt", n_inc, 1);
        cycle();
        chk("first_valid_1clk", ir_valid, 0);

        // Fetch at top of memory, counter wraps to 0
        fix_dly = 1;
        do_flush(5'h1F);
        for (int k = 0; k < 30 && n_acc < 2; k++) cycle();
        chk("wrap_timeout", n_acc >= 2, 1);
        chk("wrap_addr0", ack_log.size() > 0 ? ack_log[0] : 5'h15, 5'h1F);
        chk("wrap_addr1", ack_log.size() > 1 ? ack_log[1] : 5'h15, 5'h00);
        chk("wrap_word0", acc_log.size() > 0 ? acc_log[0] : 8'h00, 8'hE3);
        chk("wrap_inc_balance", n_inc, n_acc + q.size());

        // Controller stall for 5 clks
        ready_pct = 0;
        do_flush(5'h03);
        for (int k = 0; k < 20 && !ir_valid; k++) cycle();
        chk("stall_timeout", ir_valid, 1);
        w0 = {ir_opcode, ir_operand};
        a0 = n_ack;
        repeat (5) cycle();
        chk("stall_valid", ir_valid, 1);
        chk("stall_word", {ir_opcode, ir_operand}, w0);
        chk("stall_reqs", n_ack - a0, PF ? 1 : 0);
        chk("stall_no_rd", mem_rd, 0);
        ready_pct = 100;

        // Flush coincident with mem_ack
        fix_dly = 3;
        do_flush(5'h14);
        flush_on_ack = 1'b1; flush_tgt = 5'h0A; fa_hit = 1'b0;
        for (int k = 0; k < 20 && !fa_hit; k++) cycle();
        chk("fack_timeout", fa_hit, 1);
        chk("fack_no_inc", last_flush_inc, 0);
        cycle();
        chk("fack_no_valid", ir_valid, 0);
        cycle();
        chk("fack_rd", mem_rd, 1);
        chk("fack_addr", mem_addr, 5'h0A);

        // Throughput with 1-clk memory and always-ready controller
        fix_dly = 1;
        do_flush(5'h08);
        for (int k = 0; k < 20 && !ir_valid; k++) cycle();
        chk("tput_timeout", ir_valid, 1);
        a0 = n_acc;
        repeat (8) cycle();
        chk("tput_accepts", n_acc - a0, PF ? 8 : 4);

        // Random traffic: latency, backpressure, flushes, stray acks
        fix_dly = 0; rand_flush_pct = 2; stray_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) ready_pct = int'($urandom_range(20, 100));
            cycle();
        end
        rand_flush_pct = 0; stray_en = 1'b0; ready_pct = 0;
        repeat (20) cycle();
        chk("final_inc_balance", n_inc, n_acc + q.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
